uart_tx: RTL

- UART transmitter. Serialises one byte per accepted request onto the `tx` line as an asynchronous frame: start bit, data LSB-first, optional parity, one or two stop bits.
- Sits beside the receive-side baud clock and UART receiver. It shares their CLK_FREQ/BAUD_RATE parameterisation, so both directions of the link run at the same bit rate.
- Owns its own bit-period timer, aligned to frame start rather than free-running.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_tx_if.sv | 14 +
 rtl/uart_bit_timer.sv | 30 +++
 rtl/uart_tx.sv | 122 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity encodings and baud helpers
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  function automatic int unsigned bit_ticks(input int unsigned clk_freq, input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned timer_width(input int unsigned ticks);
    return (ticks < 2) ? 1 : $clog2(ticks);
  endfunction

  // Parity over the low nbits only; upper byte bits never reach the line.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned nbits,
                                      input int unsigned mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - request handshake and line outputs of the UART transmitter
interface uart_tx_if;
  import uart_pkg::*;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;

  modport master (output tx_data, output tx_valid, input tx_ready, input tx, input tx_busy);
  modport slave  (input tx_data, input tx_valid, output tx_ready, output tx, output tx_busy);

endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - frame-aligned bit-period counter with one-cycle bit_done pulse
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned BIT_TICKS = 10
) (
  input  logic clk,
  input  logic set,
  input  logic clear_i,
  output logic bit_done_o
);

  localparam int unsigned W = timer_width(BIT_TICKS);
  localparam logic [W-1:0] LAST = W'(BIT_TICKS - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge set) begin
    if (!set) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bit_done_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic     clk,
  input  logic     set,
  uart_tx_if.slave bus
);

  localparam int unsigned BIT_TICKS = bit_ticks(CLK_FREQ, BAUD_RATE);

  generate
    if (BIT_TICKS < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY > 2) begin : g_bad_params
      $error("uart_tx: illegal parameter combination");
    end
  endgenerate

  tx_state_e  state_q;
  logic [7:0] shift_q;
  logic [2:0] idx_q;
  logic       stop_q;
  logic       par_q;
  logic       tx_q;
  logic       busy_q;
  logic       ready_q;
  logic       bit_done;

  // The timer is held at zero while idle, so every frame starts a fresh bit period.
  uart_bit_timer #(.BIT_TICKS(BIT_TICKS)) u_timer (
    .clk       (clk),
    .set       (set),
    .clear_i   (state_q == TX_IDLE),
    .bit_done_o(bit_done)
  );

  always_ff @(posedge clk or negedge set) begin
    if (!set) begin
      state_q <= TX_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (bus.tx_valid && ready_q) begin
            shift_q <= bus.tx_data;
            par_q   <= parity_bit(bus.tx_data, DATA_BITS, PARITY);
            idx_q   <= '0;
            state_q <= TX_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        TX_START: begin
          if (bit_done) begin
            state_q <= TX_DATA;
            tx_q    <= shift_q[0];
          end
        end
        TX_DATA: begin
          if (bit_done) begin
            shift_q <= shift_q >> 1;
            if (idx_q == 3'(DATA_BITS - 1)) begin
              if (PARITY != PAR_NONE) begin
                state_q <= TX_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= TX_STOP;
                tx_q    <= 1'b1;
                stop_q  <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end
        end
        TX_PARITY: begin
          if (bit_done) begin
            state_q <= TX_STOP;
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
          end
        end
        TX_STOP: begin
          if (bit_done) begin
            if (stop_q == 1'(STOP_BITS - 1)) begin
              state_q <= TX_IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= TX_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_ready = ready_q;

endmodule
